// File: rtl/pwm_duty_scheduler_if.sv
// Host write port of the PWM duty scheduler: valid/ready handshake carrying
// a channel index and a requested duty.
interface pwm_duty_scheduler_if #(
   parameter int unsigned CW = 7
);
   logic          wr_valid;
   logic [1:0]    wr_ch;
   logic [CW-1:0] wr_duty;
   logic          wr_ready;

   modport master (
      output wr_valid,
      output wr_ch,
      output wr_duty,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_ch,
      input  wr_duty,
      output wr_ready
   );
endinterface

// File: rtl/pwm_duty_scheduler.sv
// Three-channel PWM with one shared period counter. Each channel's active duty
// ramps toward its host-written target by at most STEP per period boundary.
module pwm_duty_scheduler #(
   parameter int unsigned PERIOD = 100,
   parameter int unsigned CW     = 7,
   parameter int unsigned STEP   = 5
) (
   input  logic                       CLK_in,
   input  logic                       RST,
   pwm_duty_scheduler_if.slave        wr,
   output logic [2:0]                 PWM_out,
   output logic [2:0]                 busy,
   output logic                       period_start
);

   localparam logic [CW-1:0] LAST_C = CW'(PERIOD - 1);
   localparam logic [CW-1:0] FULL_C = CW'(PERIOD);
   localparam logic [CW:0]   STEP_C = (CW+1)'(STEP);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] target_q [3];
   logic [CW-1:0] target_d [3];
   logic [CW-1:0] active_q [3];
   logic [CW-1:0] active_d [3];
   logic [2:0]    pwm_q, pwm_d;
   logic          ready_q;
   logic          boundary_s;
   logic          wr_fire_s;

   // The sum and the difference are formed one bit wider so neither wraps.
   function automatic logic [CW-1:0] ramp_f(input logic [CW-1:0] act,
                                             input logic [CW-1:0] tgt);
      logic [CW:0]   sum_s;
      logic [CW:0]   diff_s;
      logic [CW-1:0] res_s;
      sum_s  = {1'b0, act} + STEP_C;
      diff_s = {1'b0, act} - {1'b0, tgt};
      if (act < tgt) begin
         res_s = (sum_s > {1'b0, tgt}) ? tgt : sum_s[CW-1:0];
      end else if (act > tgt) begin
         res_s = (diff_s > STEP_C) ? (act - STEP_C[CW-1:0]) : tgt;
      end else begin
         res_s = act;
      end
      return res_s;
   endfunction

   function automatic logic [CW-1:0] sat_f(input logic [CW-1:0] duty);
      return (duty > FULL_C) ? FULL_C : duty;
   endfunction

   assign boundary_s = (cnt_q == LAST_C);
   assign wr_fire_s  = wr.wr_valid && ready_q;

   // Next-state: counter wrap, target capture, boundary ramp, PWM compare.
   always_comb begin
      cnt_d = boundary_s ? {CW{1'b0}} : (cnt_q + {{(CW-1){1'b0}}, 1'b1});
      pwm_d = 3'b000;
      for (int i = 0; i < 3; i++) begin
         target_d[i] = target_q[i];
         active_d[i] = active_q[i];
         if (wr_fire_s && (int'(wr.wr_ch) == i)) begin
            target_d[i] = sat_f(wr.wr_duty);
         end else begin
            target_d[i] = target_q[i];
         end
         if (boundary_s) begin
            active_d[i] = ramp_f(active_q[i], target_q[i]);
         end else begin
            active_d[i] = active_q[i];
         end
         pwm_d[i] = (cnt_q < active_q[i]);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK_in) begin
      if (RST) begin
         cnt_q   <= {CW{1'b0}};
         pwm_q   <= 3'b000;
         ready_q <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            target_q[i] <= {CW{1'b0}};
            active_q[i] <= {CW{1'b0}};
         end
      end else begin
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_d;
         ready_q <= 1'b1;
         for (int i = 0; i < 3; i++) begin
            target_q[i] <= target_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   // Status decode straight from the registers.
   always_comb begin
      busy = 3'b000;
      for (int i = 0; i < 3; i++) begin
         busy[i] = (active_q[i] != target_q[i]);
      end
   end

   assign period_start = (cnt_q == {CW{1'b0}});
   assign PWM_out      = pwm_q;
   assign wr.wr_ready  = ready_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Scoreboard bench for pwm_duty_scheduler: a period-level reference model
// predicts the high count of each PWM window and the status outputs.
module tb_pwm_duty_scheduler;
   localparam int PERIOD = 100;
   localparam int CW     = 7;
   localparam int STEP   = 5;

   typedef struct {
      int h0;
      int h1;
      int h2;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] pwm;
   logic [2:0] busy;
   logic       pstart;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (post-edge view).
   int   m_cnt = 0;
   int   m_tgt [3];
   int   m_act [3];
   bit   m_ready = 1'b0;
   bit   m_rst_edge = 1'b1;
   exp_t exp_q [$];

   pwm_duty_scheduler_if #(.CW(CW)) bus ();

   pwm_duty_scheduler #(.PERIOD(PERIOD), .CW(CW), .STEP(STEP)) dut (
      .CLK_in       (clk),
      .RST          (rst),
      .wr           (bus),
      .PWM_out      (pwm),
      .busy         (busy),
      .period_start (pstart)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int ramp(input int a, input int t);
      if (a < t) return (a + STEP < t) ? a + STEP : t;
      if (a > t) return (a - STEP > t) ? a - STEP : t;
      return a;
   endfunction

   // Reference model: advances once per rising edge from the pre-edge inputs.
   initial begin
      for (int i = 0; i < 3; i++) begin
         m_tgt[i] = 0;
         m_act[i] = 0;
      end
      forever begin
         @(posedge clk);
         if (rst) begin
            m_cnt = 0;
            m_ready = 1'b0;
            m_rst_edge = 1'b1;
            for (int i = 0; i < 3; i++) begin
               m_tgt[i] = 0;
               m_act[i] = 0;
            end
            exp_q.delete();
         end else begin
            m_rst_edge = 1'b0;
            if (m_cnt == 0) exp_q.push_back('{m_act[0], m_act[1], m_act[2]});
            if (m_cnt == PERIOD - 1) begin
               for (int i = 0; i < 3; i++) m_act[i] = ramp(m_act[i], m_tgt[i]);
            end
            if (bus.wr_valid && m_ready && bus.wr_ch != 2'd3)
               m_tgt[bus.wr_ch] = (int'(bus.wr_duty) > PERIOD) ? PERIOD : int'(bus.wr_duty);
            m_cnt = (m_cnt + 1) % PERIOD;
            m_ready = 1'b1;
         end
      end
   end

   // Monitor: status every cycle, PWM pulse shape and high count per window.
   initial begin
      exp_t cur;
      bit   in_win = 1'b0;
      int   pos = 0;
      int   hc [3];
      logic [2:0] exp_bits;
      logic [2:0] exp_busy;
      cur = '{0, 0, 0};
      for (int i = 0; i < 3; i++) hc[i] = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) exp_busy[i] = (m_act[i] != m_tgt[i]);
         check("wr_ready", {7'd0, bus.wr_ready}, {7'd0, m_ready});
         check("busy", {5'd0, busy}, {5'd0, exp_busy});
         check("period_start", {7'd0, pstart}, {7'd0, (m_cnt == 0)});
         if (m_rst_edge) begin
            in_win = 1'b0;
            check("pwm_reset", {5'd0, pwm}, 8'd0);
         end else begin
            if (m_cnt == 1) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL window_start: got empty queue, expected a period entry at %0t", $time);
                  in_win = 1'b0;
               end else begin
                  cur = exp_q.pop_front();
                  in_win = 1'b1;
                  pos = 0;
                  for (int i = 0; i < 3; i++) hc[i] = 0;
               end
            end
            if (in_win) begin
               exp_bits = {(pos < cur.h2), (pos < cur.h1), (pos < cur.h0)};
               check("pwm_shape", {5'd0, pwm}, {5'd0, exp_bits});
               for (int i = 0; i < 3; i++) hc[i] += int'(pwm[i]);
               pos++;
               if (m_cnt == 0) begin
                  check("high_count_ch0", 8'(hc[0]), 8'(cur.h0));
                  check("high_count_ch1", 8'(hc[1]), 8'(cur.h1));
                  check("high_count_ch2", 8'(hc[2]), 8'(cur.h2));
                  in_win = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cnt(input int c);
      int k = 0;
      while (m_cnt != c && k < 3 * PERIOD) begin
         @(negedge clk);
         k++;
      end
      if (m_cnt != c) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_cnt: got cnt %0d, expected %0d within budget", m_cnt, c);
      end
   endtask

   task automatic write(input int ch, input int duty);
      logic [1:0]    ch_v;
      logic [CW-1:0] duty_v;
      ch_v   = 2'(ch);
      duty_v = CW'(duty);
      bus.wr_valid = 1'b1;
      bus.wr_ch    = ch_v;
      bus.wr_duty  = duty_v;
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   // Stimulus: directed scenarios followed by a randomized phase.
   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_ch    = 2'd0;
      bus.wr_duty  = '0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(PERIOD + 20);
      wait_cnt(40);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(PERIOD + 5);

      wait_cnt(10);
      write(0, 25);
      tick(7 * PERIOD);

      write(2, 120);
      write(1, 50);
      tick(22 * PERIOD);
      write(1, 48);
      write(1, 12);
      tick(10 * PERIOD);

      wait_cnt(99);
      write(0, 10);
      tick(3 * PERIOD);
      write(3, 50);
      tick(3 * PERIOD);

      write(0, 20);
      tick(4 * PERIOD);
      write(0, 60);
      tick(2 * PERIOD + 30);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2 * PERIOD);

      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 599) == 0);
         bus.wr_valid = ($urandom_range(0, 3) == 0);
         bus.wr_ch    = 2'($urandom_range(0, 3));
         bus.wr_duty  = CW'($urandom_range(0, 127));
         @(negedge clk);
      end
      rst = 1'b0;
      bus.wr_valid = 1'b0;
      tick(2 * PERIOD + 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #1000000;
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got no finish, expected end before %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
